// File: rtl/ee290_bmm_accel_strided.sv
// RoCC accelerator: XOR-accumulated GF(2) bit-matrix product over strided operand
// streams, with optional result store, s2_nack replay and tag-matched cache responses.
module ee290_bmm_accel_strided #(
  parameter int XLEN  = 64,  // must equal DIM*DIM (one packed matrix per word)
  parameter int DIM   = 8,
  parameter int CNT_W = 16,
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       funct,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [4:0]       rd,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [4:0]       resp_rd,
  output logic [XLEN-1:0]  resp_data,
  output logic             busy,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic [TAG_W-1:0] mem_req_tag,
  output logic             mem_req_wen,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             s2_nack,
  input  logic             mem_resp_valid,
  input  logic [TAG_W-1:0] mem_resp_tag,
  input  logic [XLEN-1:0]  mem_resp_data
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_REQ_A      = 4'd1;
  localparam logic [3:0] S_WAIT_A     = 4'd2;
  localparam logic [3:0] S_REQ_B      = 4'd3;
  localparam logic [3:0] S_WAIT_B     = 4'd4;
  localparam logic [3:0] S_PROC       = 4'd5;
  localparam logic [3:0] S_STORE_REQ  = 4'd6;
  localparam logic [3:0] S_STORE_WAIT = 4'd7;
  localparam logic [3:0] S_RESP       = 4'd8;

  localparam logic [6:0] F_COMPUTE       = 7'd0;
  localparam logic [6:0] F_CFG_CNT       = 7'd1;
  localparam logic [6:0] F_CFG_STORE     = 7'd2;
  localparam logic [6:0] F_COMPUTE_STORE = 7'd3;

  localparam logic [TAG_W-2:0] SEQ_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [3:0]       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] nack_cnt;
  logic [XLEN-1:0]  stride_a;
  logic [XLEN-1:0]  stride_b;
  logic [XLEN-1:0]  store_addr;
  logic [XLEN-1:0]  ptr_a;
  logic [XLEN-1:0]  ptr_b;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  wdata_q;
  logic [TAG_W-2:0] seq;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       wait_cyc;
  logic [4:0]       rd_q;
  logic             store_mode;

  logic             req_fire;
  logic             nack_hit;
  logic             resp_hit;
  logic [CNT_W-1:0] nack_next;

  function automatic logic [XLEN-1:0] bmm(input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        for (int k = 0; k < DIM; k++)
          r[i*DIM+j] = r[i*DIM+j] ^ (a[i*DIM+k] & b[k*DIM+j]);
    return r;
  endfunction

  assign req_fire  = mem_req_valid & mem_req_ready;
  // The cache reports a nack on a fixed pipeline slot: two cycles after the fire.
  assign nack_hit  = s2_nack && (wait_cyc == 2'd2);
  assign resp_hit  = mem_resp_valid && (mem_resp_tag == out_tag);
  assign nack_next = (nack_cnt == '1) ? nack_cnt : nack_cnt + CNT_ONE;

  // cmd_ready is gated by reset so it reads 0 while reset is held.
  assign cmd_ready = reset && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign mem_wdata = wdata_q;

  always_comb begin
    // NOTE: every output is given a default first so no path through the case infers a latch.
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_tag   = '0;
    mem_req_wen   = 1'b0;
    resp_valid    = 1'b0;
    resp_rd       = '0;
    resp_data     = '0;
    case (state)
      S_REQ_A: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ptr_a;
        mem_req_tag   = {seq, 1'b0};
      end
      S_REQ_B: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ptr_b;
        mem_req_tag   = {seq, 1'b1};
      end
      S_STORE_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = store_addr;
        mem_req_tag   = {seq, 1'b1};
        mem_req_wen   = 1'b1;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rd    = rd_q;
        resp_data  = store_mode ? {{(XLEN-CNT_W){1'b0}}, nack_cnt} : acc;
      end
      default: ;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      idx        <= '0;
      nack_cnt   <= '0;
      stride_a   <= '0;
      stride_b   <= '0;
      store_addr <= '0;
      ptr_a      <= '0;
      ptr_b      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      wdata_q    <= '0;
      seq        <= '0;
      out_tag    <= '0;
      wait_cyc   <= '0;
      rd_q       <= '0;
      store_mode <= 1'b0;
    end else begin
      wdata_q <= '0;
      if (req_fire) begin
        seq      <= seq + SEQ_ONE;
        out_tag  <= mem_req_tag;
        wait_cyc <= 2'd1;
      end else if (wait_cyc != 2'd3) begin
        wait_cyc <= wait_cyc + 2'd1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (funct)
              F_CFG_CNT: begin
                count    <= rs1[CNT_W-1:0];
                stride_a <= {{(XLEN-32){1'b0}}, rs2[31:0]};
                stride_b <= {{(XLEN-32){1'b0}}, rs2[63:32]};
              end
              F_CFG_STORE: store_addr <= rs1;
              F_COMPUTE, F_COMPUTE_STORE: begin
                ptr_a      <= rs1;
                ptr_b      <= rs2;
                rd_q       <= rd;
                acc        <= '0;
                idx        <= '0;
                nack_cnt   <= '0;
                store_mode <= (funct == F_COMPUTE_STORE);
                if (count == '0)
                  state <= (funct == F_COMPUTE_STORE) ? S_STORE_REQ : S_RESP;
                else
                  state <= S_REQ_A;
              end
              default: ;
            endcase
          end
        end
        S_REQ_A: if (req_fire) state <= S_WAIT_A;
        S_WAIT_A: begin
          if (nack_hit) begin
            nack_cnt <= nack_next;
            state    <= S_REQ_A;
          end else if (resp_hit) begin
            op_a  <= mem_resp_data;
            state <= S_REQ_B;
          end
        end
        S_REQ_B: if (req_fire) state <= S_WAIT_B;
        S_WAIT_B: begin
          if (nack_hit) begin
            nack_cnt <= nack_next;
            state    <= S_REQ_B;
          end else if (resp_hit) begin
            op_b  <= mem_resp_data;
            state <= S_PROC;
          end
        end
        S_PROC: begin
          acc   <= acc ^ bmm(op_a, op_b);
          ptr_a <= ptr_a + stride_a;
          ptr_b <= ptr_b + stride_b;
          idx   <= idx + CNT_ONE;
          if (idx == count - CNT_ONE)
            state <= store_mode ? S_STORE_REQ : S_RESP;
          else
            state <= S_REQ_A;
        end
        S_STORE_REQ: begin
          if (req_fire) begin
            wdata_q <= acc;
            state   <= S_STORE_WAIT;
          end
        end
        S_STORE_WAIT: begin
          // Stores complete on their ack, or once the nack slot has passed quietly.
          if (nack_hit) begin
            nack_cnt <= nack_next;
            state    <= S_STORE_REQ;
          end else if (resp_hit || (wait_cyc == 2'd3)) begin
            state <= S_RESP;
          end
        end
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ee290_bmm_accel_strided.sv
// Directed bench for ee290_bmm_accel_strided: strided loads, nack replay, stale tags,
// compute-and-store, response backpressure and mid-operation reset.
module tb_ee290_bmm_accel_strided;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  funct;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [4:0]  rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        busy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic [7:0]  mem_req_tag;
  logic        mem_req_wen;
  logic [63:0] mem_wdata;
  logic        s2_nack;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_tag;
  logic [63:0] mem_resp_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [6:0]  seq_m = '0;

  localparam logic [63:0] IDENT = 64'h8040201008040201;
  localparam logic [63:0] BV    = 64'h0123456789ABCDEF;
  localparam logic [63:0] ANTI  = 64'h0102040810204080;

  ee290_bmm_accel_strided dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .funct(funct),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_data(resp_data), .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_wen(mem_req_wen), .mem_wdata(mem_wdata), .s2_nack(s2_nack),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cmd_ready"}, cmd_ready, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_resp_valid"}, resp_valid, 0);
    chk({name, "_resp_rd"}, resp_rd, 0);
    chk({name, "_resp_data"}, resp_data, 0);
    chk({name, "_req_valid"}, mem_req_valid, 0);
    chk({name, "_req_addr"}, mem_req_addr, 0);
    chk({name, "_req_tag"}, mem_req_tag, 0);
    chk({name, "_req_wen"}, mem_req_wen, 0);
    chk({name, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic send(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] r);
    for (int w = 0; w < 100 && !cmd_ready; w++) @(negedge clock);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; funct = f; rs1 = a; rs2 = b; rd = r;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // One memory transaction: optional stale response in WAIT, optional nack on first try.
  task automatic serve(input logic [63:0] addr, input logic wen, input logic kind,
                       input bit nack, input bit stale, input logic [63:0] rdata,
                       input logic [63:0] wexp);
    logic [7:0] tag;
    int tries;
    tries = nack ? 2 : 1;
    for (int t = 0; t < tries; t++) begin
      for (int w = 0; w < 50 && !mem_req_valid; w++) @(negedge clock);
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, addr);
      chk("req_wen", mem_req_wen, wen);
      chk("req_tag", mem_req_tag, {seq_m, kind});
      tag = mem_req_tag;
      mem_req_ready = 1'b1;
      @(negedge clock);
      mem_req_ready = 1'b0;
      seq_m++;
      chk("one_outstanding", mem_req_valid, 0);
      if (wen) chk("store_wdata", mem_wdata, wexp);
      if (stale && t == 0) begin
        mem_resp_valid = 1'b1; mem_resp_tag = tag ^ 8'h02; mem_resp_data = ~rdata;
      end
      @(negedge clock);
      mem_resp_valid = 1'b0;
      if (nack && t == 0) s2_nack = 1'b1;
      else if (!wen) begin
        mem_resp_valid = 1'b1; mem_resp_tag = tag; mem_resp_data = rdata;
      end
      @(negedge clock);
      s2_nack = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    end
  endtask

  task automatic get_resp(input logic [4:0] rdx, input logic [63:0] data);
    for (int w = 0; w < 100 && !resp_valid; w++) @(negedge clock);
    chk("resp_valid", resp_valid, 1);
    chk("resp_rd", resp_rd, rdx);
    chk("resp_data", resp_data, data);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("busy_after_resp", busy, 0);
    chk("cmd_ready_after_resp", cmd_ready, 1);
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1;
    cmd_valid = 1'b0; funct = '0; rs1 = '0; rs2 = '0; rd = '0;
    resp_ready = 1'b0; mem_req_ready = 1'b0; s2_nack = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    #2 reset = 1'b0;
    @(negedge clock);
    chk_all_zero("in_reset");
    @(negedge clock);
    reset = 1'b1;
    #1 chk("cmd_ready_after_reset", cmd_ready, 1);
    @(negedge clock);

    // Identity x B over one element
    send(7'd1, 64'd1, 64'd0, 5'd0);
    send(7'd0, 64'h100, 64'h200, 5'd5);
    serve(64'h100, 1'b0, 1'b0, 0, 0, IDENT, '0);
    serve(64'h200, 1'b0, 1'b1, 0, 0, BV, '0);
    get_resp(5'd5, BV);

    // Two identity products with stride 8 cancel
    send(7'd1, 64'd2, {32'd8, 32'd8}, 5'd0);
    send(7'd0, 64'h100, 64'h200, 5'd6);
    serve(64'h100, 1'b0, 1'b0, 0, 0, IDENT, '0);
    serve(64'h200, 1'b0, 1'b1, 0, 0, IDENT, '0);
    serve(64'h108, 1'b0, 1'b0, 0, 0, IDENT, '0);
    serve(64'h208, 1'b0, 1'b1, 0, 0, IDENT, '0);
    get_resp(5'd6, 64'd0);

    // stride_a = 16, stride_b = 0: B ^ 0x22 ^ byte-reversed B
    send(7'd1, 64'd3, 64'h0000_0000_0000_0010, 5'd0);
    send(7'd0, 64'h400, 64'h800, 5'd7);
    serve(64'h400, 1'b0, 1'b0, 0, 0, IDENT, '0);
    serve(64'h800, 1'b0, 1'b1, 0, 0, BV, '0);
    serve(64'h410, 1'b0, 1'b0, 0, 0, 64'h3, '0);
    serve(64'h800, 1'b0, 1'b1, 0, 0, BV, '0);
    serve(64'h420, 1'b0, 1'b0, 0, 0, ANTI, '0);
    serve(64'h800, 1'b0, 1'b1, 0, 0, BV, '0);
    get_resp(5'd7, 64'hEEEE_EEEE_EEEE_EECC);

    // Stale tag during WAIT_A, nack on the B load
    send(7'd1, 64'd1, 64'd0, 5'd0);
    send(7'd0, 64'h40, 64'h80, 5'd8);
    serve(64'h40, 1'b0, 1'b0, 0, 1, IDENT, '0);
    serve(64'h80, 1'b0, 1'b1, 1, 0, 64'h1122334455667788, '0);
    get_resp(5'd8, 64'h1122334455667788);

    // Unknown funct is swallowed
    send(7'd9, 64'd0, 64'd0, 5'd3);
    chk("unknown_busy", busy, 0);
    chk("unknown_resp_valid", resp_valid, 0);

    // Compute-and-store with one nacked store
    send(7'd2, 64'h1000, 64'd0, 5'd0);
    send(7'd3, 64'h40, 64'h80, 5'd9);
    serve(64'h40, 1'b0, 1'b0, 0, 0, IDENT, '0);
    serve(64'h80, 1'b0, 1'b1, 0, 0, 64'hCAFEF00DDEADBEEF, '0);
    serve(64'h1000, 1'b1, 1'b1, 1, 0, '0, 64'hCAFEF00DDEADBEEF);
    get_resp(5'd9, 64'd1);

    // count == 0 answers at once with no memory traffic
    send(7'd1, 64'd0, 64'd0, 5'd0);
    send(7'd0, 64'h40, 64'h80, 5'd10);
    chk("cnt0_no_req", mem_req_valid, 0);
    get_resp(5'd10, 64'd0);

    // Response backpressure; a pending CFG_CNT must not be taken meanwhile
    send(7'd1, 64'd1, 64'd0, 5'd0);
    send(7'd0, 64'h40, 64'h80, 5'd11);
    serve(64'h40, 1'b0, 1'b0, 0, 0, IDENT, '0);
    serve(64'h80, 1'b0, 1'b1, 0, 0, BV, '0);
    for (int w = 0; w < 20 && !resp_valid; w++) @(negedge clock);
    cmd_valid = 1'b1; funct = 7'd1; rs1 = 64'd0; rs2 = 64'd0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, BV);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    get_resp(5'd11, BV);

    // Reset while waiting for B
    send(7'd0, 64'h40, 64'h80, 5'd12);
    serve(64'h40, 1'b0, 1'b0, 0, 0, IDENT, '0);
    for (int w = 0; w < 50 && !mem_req_valid; w++) @(negedge clock);
    chk("rst_b_addr", mem_req_addr, 64'h80);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    reset = 1'b0;
    #1 chk_all_zero("mid_reset");
    seq_m = '0;
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_tag = 8'h03; mem_resp_data = BV;
    @(negedge clock);
    mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk("post_rst_no_resp", resp_valid, 0);
      chk("post_rst_idle", busy, 0);
    end

    // Cleared count answers immediately; cleared seq restarts tags at 0
    send(7'd0, 64'h40, 64'h80, 5'd13);
    chk("post_rst_no_req", mem_req_valid, 0);
    get_resp(5'd13, 64'd0);
    send(7'd1, 64'd1, 64'd0, 5'd0);
    send(7'd0, 64'h40, 64'h80, 5'd14);
    serve(64'h40, 1'b0, 1'b0, 0, 0, ANTI, '0);
    serve(64'h80, 1'b0, 1'b1, 0, 0, BV, '0);
    get_resp(5'd14, 64'hEFCDAB8967452301);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
